// File: rtl/mac_pkg.sv
// ============================================================================
// Module  : mac_pkg
// Brief   : Shared widths and FSM state encodings for the 4-bit MAC block.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mac_pkg;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_ACC_WIDTH  = 12;
  localparam int DEF_CNT_WIDTH  = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ACCUM = ST_ACCUM,
    DRAIN = ST_DRAIN,
    HOLD  = ST_HOLD
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mac_accum_4bit_if.sv
// ============================================================================
// Module  : mac_accum_4bit_if
// Brief   : Operand input and frame result handshake bundle of the MAC block.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface mac_accum_4bit_if
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
);

  logic                  valid_in;
  logic                  ready_out;
  logic [DATA_WIDTH-1:0] x_in;
  logic [DATA_WIDTH-1:0] y_in;
  logic                  last_in;
  logic                  valid_out;
  logic                  ready_in;
  logic [ACC_WIDTH-1:0]  acc_out;
  logic [CNT_WIDTH-1:0]  count_out;
  logic                  overflow_out;

  modport master (
    output valid_in, x_in, y_in, last_in, ready_in,
    input  ready_out, valid_out, acc_out, count_out, overflow_out
  );

  modport slave (
    input  valid_in, x_in, y_in, last_in, ready_in,
    output ready_out, valid_out, acc_out, count_out, overflow_out
  );

endinterface

`default_nettype wire

// File: rtl/mac_accum_4bit_mult.sv
// ============================================================================
// Module  : multiplier_4bit
// Brief   : Combinational unsigned multiplier, full-width product.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module multiplier_4bit #(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0]   x_in,
  input  logic [DATA_WIDTH-1:0]   y_in,
  output logic [2*DATA_WIDTH-1:0] prod_out
);

  assign prod_out = (2*DATA_WIDTH)'(x_in) * (2*DATA_WIDTH)'(y_in);

endmodule

`default_nettype wire

// File: rtl/mac_accum_4bit.sv
// ============================================================================
// Module  : mac_accum_4bit
// Brief   : Framed multiply-accumulate: two-stage product/accumulate pipeline,
//           saturating term counter, sticky overflow, result held until taken.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_accum_4bit
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic            clk_in,
  input  logic            rst_in,
  mac_accum_4bit_if.slave bus
);

  localparam int                   c_PW      = 2 * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_ready;
  logic                   w_valid;
  logic                   w_accept;
  logic                   w_clear;
  logic [c_PW-1:0]        w_prod;
  logic [ACC_WIDTH:0]     w_sum;

  logic [c_PW-1:0]        r_p1_prod;
  logic                   r_p1_last;
  logic                   r_p1_vld;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_ovf;

  multiplier_4bit #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mult (
    .x_in     (bus.x_in),
    .y_in     (bus.y_in),
    .prod_out (w_prod)
  );

  assign w_accept = bus.valid_in & w_ready;
  assign w_clear  = (r_state == HOLD) & bus.ready_in;
  // Extra MSB of the sum is the carry that sets the sticky overflow flag.
  assign w_sum    = {1'b0, r_acc} + (ACC_WIDTH + 1)'(r_p1_prod);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.valid_in) begin
          w_state_nxt = bus.last_in ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        w_ready = 1'b1;
        if (bus.valid_in && bus.last_in) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Only a last-flagged product ever enters DRAIN; anything else is dropped.
        w_state_nxt = r_p1_last ? HOLD : IDLE;
      end
      HOLD: begin
        w_valid = 1'b1;
        if (bus.ready_in) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_p1_prod <= '0;
      r_p1_last <= 1'b0;
      r_p1_vld  <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_p1_vld <= w_accept;
      if (w_accept) begin
        r_p1_prod <= w_prod;
        r_p1_last <= bus.last_in;
      end
      if (w_clear) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (r_p1_vld) begin
          r_acc <= w_sum[ACC_WIDTH-1:0];
          if (w_sum[ACC_WIDTH]) begin
            r_ovf <= 1'b1;
          end
        end
        if (w_accept && (r_cnt != c_CNT_MAX)) begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.ready_out    = w_ready;
  assign bus.valid_out    = w_valid;
  assign bus.acc_out      = r_acc;
  assign bus.count_out    = r_cnt;
  assign bus.overflow_out = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mac_accum_4bit.sv
// ============================================================================
// Module  : tb_mac_accum_4bit
// Brief   : Self-checking bench for mac_accum_4bit against a sum-of-products model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mac_accum_4bit;

  localparam int c_DW  = 4;
  localparam int c_AW  = 12;
  localparam int c_CW  = 8;
  localparam int c_ACC_MOD = 1 << c_AW;
  localparam int c_CNT_MAX = (1 << c_CW) - 1;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  int   qx[$];
  int   qy[$];
  int   qg[$];

  mac_accum_4bit_if #(.DATA_WIDTH(c_DW), .ACC_WIDTH(c_AW), .CNT_WIDTH(c_CW)) bus ();

  mac_accum_4bit #(
    .DATA_WIDTH (c_DW),
    .ACC_WIDTH  (c_AW),
    .CNT_WIDTH  (c_CW)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int x, input int y, input int gap);
    qx.push_back(x);
    qy.push_back(y);
    qg.push_back(gap);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid_out"}, 32'(bus.valid_out), 0);
    chk({tag, ".acc"},       32'(bus.acc_out), 0);
    chk({tag, ".count"},     32'(bus.count_out), 0);
    chk({tag, ".ovf"},       32'(bus.overflow_out), 0);
    chk({tag, ".ready_out"}, 32'(bus.ready_out), 1);
  endtask

  // Plays the queued frame, then checks the result against plain arithmetic.
  task automatic play(input string tag, input int hold_cycles);
    longint sum = 0;
    int     n   = qx.size();
    int     e_acc, e_cnt, e_ovf;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < qg[i]; g++) begin
        bus.valid_in = 1'b0;
        bus.x_in     = 4'($urandom);
        bus.y_in     = 4'($urandom);
        bus.last_in  = 1'($urandom);
        tick();
      end
      bus.valid_in = 1'b1;
      bus.x_in     = 4'(qx[i]);
      bus.y_in     = 4'(qy[i]);
      bus.last_in  = (i == n - 1);
      chk({tag, ".ready_in_frame"}, 32'(bus.ready_out), 1);
      tick();
      sum += qx[i] * qy[i];
    end
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
    e_acc = int'(sum % c_ACC_MOD);
    e_cnt = (n > c_CNT_MAX) ? c_CNT_MAX : n;
    e_ovf = (sum > c_ACC_MOD - 1) ? 1 : 0;

    chk({tag, ".lat1_valid"}, 32'(bus.valid_out), 0);
    chk({tag, ".lat1_ready"}, 32'(bus.ready_out), 0);
    tick();
    chk({tag, ".valid_out"}, 32'(bus.valid_out), 1);
    chk({tag, ".acc"},       32'(bus.acc_out), 32'(e_acc));
    chk({tag, ".count"},     32'(bus.count_out), 32'(e_cnt));
    chk({tag, ".ovf"},       32'(bus.overflow_out), 32'(e_ovf));

    for (int h = 0; h < hold_cycles; h++) begin
      bus.valid_in = 1'($urandom);
      bus.x_in     = 4'($urandom);
      bus.y_in     = 4'($urandom);
      bus.last_in  = 1'($urandom);
      chk({tag, ".hold_ready"}, 32'(bus.ready_out), 0);
      tick();
      chk({tag, ".hold_valid"}, 32'(bus.valid_out), 1);
      chk({tag, ".hold_acc"},   32'(bus.acc_out), 32'(e_acc));
      chk({tag, ".hold_count"}, 32'(bus.count_out), 32'(e_cnt));
      chk({tag, ".hold_ovf"},   32'(bus.overflow_out), 32'(e_ovf));
    end

    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    tick();
    bus.ready_in = 1'b0;
    chk_idle({tag, ".consumed"});
    qx.delete();
    qy.delete();
    qg.delete();
  endtask

  initial begin
    n_total      = 0;
    n_bad        = 0;
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    bus.x_in     = '0;
    bus.y_in     = '0;
    bus.last_in  = 1'b0;
    bus.ready_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_idle("reset");

    push(3, 5, 0); push(15, 15, 0); push(0, 9, 0);
    play("three_terms", 0);

    push(15, 15, 0);
    play("single", 2);

    for (int i = 0; i < 19; i++) push(15, 15, 0);
    play("wrap19", 0);
    for (int i = 0; i < 18; i++) push(15, 15, 0);
    play("nowrap18", 0);

    push(9, 9, 0);
    play("hold5", 5);
    push(2, 3, 0);
    play("after_hold", 0);

    // Mid-frame reset, with a competing last-term handshake in the reset cycle.
    bus.valid_in = 1'b1; bus.x_in = 4'd5; bus.y_in = 4'd7; bus.last_in = 1'b0;
    tick();
    bus.x_in = 4'd3; bus.y_in = 4'd3;
    tick();
    rst = 1'b1; bus.x_in = 4'd15; bus.y_in = 4'd15; bus.last_in = 1'b1;
    tick();
    rst = 1'b0; bus.valid_in = 1'b0; bus.last_in = 1'b0;
    chk_idle("midreset");
    tick();
    tick();
    chk_idle("midreset_flush");
    push(1, 1, 0);
    play("post_reset", 0);

    push(4, 4, 0); push(2, 2, 3);
    play("gapped", 1);

    for (int i = 0; i < 260; i++) push(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
    play("cnt_sat", 0);

    for (int f = 0; f < 8; f++) begin
      int len = int'($urandom_range(1, 25));
      for (int i = 0; i < len; i++)
        push(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      play($sformatf("rand%0d", f), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
